spi_master_fifo: RTL and testbench

Second-generation SPI master sitting between a core-side streaming interface and up to NUM_CS SPI slaves. Adds TX/RX word FIFOs with valid/ready handshakes, a runtime clock divider, per-frame mode, width and chip-select configuration, and optional back-to-back words under one chip-select assertion. Full-duplex on every word; received words are pushed to the RX FIFO.

---
 rtl/spi_master_fifo.sv | 208 ++++++++++++++++++++
 tb/tb_spi_master_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_fifo.sv
// SPI master with TX/RX word FIFOs, a runtime clock divider, and per-frame
// mode/width/chip-select latched at each word start; optional CS-held chaining.
module spi_master_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CS     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(DATA_WIDTH):0] cfg_width,
  input  logic                        cfg_lsb_first,
  input  logic                        cfg_cpol,
  input  logic                        cfg_cpha,
  input  logic [DIV_WIDTH-1:0]        cfg_div,
  input  logic [$clog2(NUM_CS)-1:0]   cfg_cs_sel,
  input  logic                        cfg_cs_hold,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [DATA_WIDTH-1:0]       tx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [DATA_WIDTH-1:0]       rx_data,
  output logic                        busy,
  output logic                        rx_overflow,
  output logic                        sclk,
  output logic                        mosi,
  input  logic                        miso,
  output logic [NUM_CS-1:0]           cs_n
);

  localparam int WW = $clog2(DATA_WIDTH) + 1;
  localparam int IW = $clog2(DATA_WIDTH);
  localparam int EW = WW + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t                    state_q, state_d;
  logic [DIV_WIDTH-1:0]      cnt_q, cnt_d, div_q;
  logic [EW-1:0]             edge_q, edge_d, e;
  logic [WW-1:0]             width_q, s;
  logic                      lsb_q, cpol_q, cpha_q, hold_q;
  logic [$clog2(NUM_CS)-1:0] cs_q;
  logic [DATA_WIDTH-1:0]     txw_q, rx_q, rx_d;
  logic                      sclk_q, sclk_d, mosi_q, mosi_d, ovf_q;
  logic [NUM_CS-1:0]         cs_n_q, cs_n_d;
  logic                      tick, tx_pop, latch, rx_wr;

  // FIFOs: pointers carry one extra wrap bit to tell full from empty
  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [AW:0]           tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
  logic                  tx_empty, tx_full, rx_empty, rx_full;
  logic                  tx_push, rx_push, rx_pop;
  logic [DATA_WIDTH-1:0] tx_head;

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
  assign tx_push  = tx_valid && !tx_full;
  assign rx_push  = rx_wr && !rx_full;
  assign rx_pop   = rx_ready && !rx_empty;
  assign tx_head  = tx_mem[tx_rp_q[AW-1:0]];

  assign tx_ready    = !tx_full;
  assign rx_valid    = !rx_empty;
  assign rx_data     = rx_empty ? '0 : rx_mem[rx_rp_q[AW-1:0]];
  assign busy        = (state_q != IDLE);
  assign rx_overflow = ovf_q;
  assign sclk        = sclk_q;
  assign mosi        = mosi_q;
  assign cs_n        = cs_n_q;

  function automatic logic [WW-1:0] wclamp(input logic [WW-1:0] w);
    if (w == '0) return WW'(1);
    if (w > WW'(DATA_WIDTH)) return WW'(DATA_WIDTH);
    return w;
  endfunction

  // Position of the k-th bit on the wire within a w-bit word
  function automatic logic [IW-1:0] bitpos(input logic lsb, input logic [WW-1:0] w,
                                           input logic [WW-1:0] k);
    return IW'(lsb ? k : w - WW'(1) - k);
  endfunction

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= tx_data;
    if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rx_q;
  end

  assign tick = (cnt_q == div_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + DIV_WIDTH'(1);
    edge_d  = edge_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    rx_d    = rx_q;
    tx_pop  = 1'b0;
    latch   = 1'b0;
    rx_wr   = 1'b0;
    e       = edge_q + EW'(1);
    s       = WW'((e - EW'(1)) >> 1);
    case (state_q)
      IDLE: begin
        sclk_d = cfg_cpol;
        mosi_d = 1'b0;
        cs_n_d = '1;
        cnt_d  = '0;
        if (!tx_empty) begin
          tx_pop = 1'b1;
          latch  = 1'b1;
        end
      end
      SETUP: if (tick) begin
        state_d = XFER;
        edge_d  = '0;
      end
      XFER: if (tick) begin
        edge_d = e;
        sclk_d = ~sclk_q;
        // sample edges are odd for CPHA=0 and even for CPHA=1
        if (cpha_q ^ e[0])
          rx_d[bitpos(lsb_q, width_q, s)] = miso;
        else if (e != {width_q, 1'b0})
          mosi_d = txw_q[bitpos(lsb_q, width_q, cpha_q ? s : s + WW'(1))];
        if (e == {width_q, 1'b0}) state_d = HOLD;
      end
      HOLD: begin
        sclk_d = cpol_q;
        if (tick) begin
          rx_wr = 1'b1;
          if (hold_q && !tx_empty && cfg_cs_sel == cs_q) begin
            tx_pop = 1'b1;
            latch  = 1'b1;
          end else begin
            state_d = GAP;
            cs_n_d  = '1;
            mosi_d  = 1'b0;
          end
        end
      end
      GAP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (latch) begin
      state_d = SETUP;
      cnt_d   = '0;
      rx_d    = '0;
      sclk_d  = cfg_cpol;
      cs_n_d  = ~(NUM_CS'(1) << cfg_cs_sel);
      mosi_d  = cfg_cpha ? 1'b0 : tx_head[bitpos(cfg_lsb_first, wclamp(cfg_width), WW'(0))];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= '1;
      rx_q    <= '0;
      ovf_q   <= 1'b0;
      width_q <= '0;
      lsb_q   <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      hold_q  <= 1'b0;
      div_q   <= '0;
      cs_q    <= '0;
      txw_q   <= '0;
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      rx_q    <= rx_d;
      ovf_q   <= rx_wr && rx_full;
      if (tx_push) tx_wp_q <= tx_wp_q + (AW+1)'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + (AW+1)'(1);
      if (rx_push) rx_wp_q <= rx_wp_q + (AW+1)'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + (AW+1)'(1);
      if (latch) begin
        width_q <= wclamp(cfg_width);
        lsb_q   <= cfg_lsb_first;
        cpol_q  <= cfg_cpol;
        cpha_q  <= cfg_cpha;
        hold_q  <= cfg_cs_hold;
        div_q   <= cfg_div;
        cs_q    <= cfg_cs_sel;
        txw_q   <= tx_head;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: loopback / slave-model frames, FIFO limits,
// overflow, CS-held chaining and mid-frame reset.
module tb_spi_master_fifo;

  logic        clk = 1'b0, rst = 1'b1;
  logic [5:0]  cfg_width = 6'd8;
  logic        cfg_lsb_first = 1'b0, cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_cs_hold = 1'b0;
  logic [7:0]  cfg_div = 8'd1;
  logic [1:0]  cfg_cs_sel = 2'd0;
  logic        tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0;
  logic [31:0] tx_data = '0, rx_data;
  logic        busy, rx_overflow, sclk, mosi, miso;
  logic [3:0]  cs_n;

  int checks = 0, errors = 0;

  spi_master_fifo #(.DATA_WIDTH(32), .NUM_CS(4), .FIFO_DEPTH(8), .DIV_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .cfg_width(cfg_width), .cfg_lsb_first(cfg_lsb_first),
    .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_div(cfg_div), .cfg_cs_sel(cfg_cs_sel),
    .cfg_cs_hold(cfg_cs_hold), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .busy(busy),
    .rx_overflow(rx_overflow), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // slave: loopback, or a word presented per SPI mode from the SCLK edge count
  logic        loop = 1'b1, sl = 1'b0;
  logic [31:0] slv = '0;
  int          sedge = 0;

  always @(sclk or cs_n) begin
    if (&cs_n) sedge = 0;
    else if (sclk !== sl) sedge++;
    sl = sclk;
  end

  function automatic logic sbit(int se, logic [31:0] w, logic cpha, logic lsb, int wd);
    int idx;
    idx = cpha ? ((se == 0) ? 0 : (se - 1) / 2) : se / 2;
    if (idx >= wd) return 1'b0;
    return w[lsb ? idx : wd - 1 - idx];
  endfunction

  assign miso = loop ? mosi : sbit(sedge, slv, cfg_cpha, cfg_lsb_first, int'(cfg_width));

  // bus monitor: captures MOSI at sample edges, checks its stability, times CS
  logic        sp = 1'b0, mp = 1'b0;
  logic [3:0]  csp = 4'hF;
  logic [31:0] cap = '0;
  int          mcnt = 0, merr = 0, run = 0, last_run = 0, ovf_cnt = 0, mk = 0, mw = 0;

  always @(negedge clk) begin
    mw = int'(cfg_width);
    if (!(&cs_n) && (&csp)) begin
      mcnt = 0; cap = '0; merr = 0;
    end
    if (!(&cs_n) && !(&csp) && (sclk !== sp)) begin
      mcnt++;
      if (cfg_cpha ? (mcnt % 2 == 0) : (mcnt % 2 == 1)) begin
        if (mosi !== mp) merr++;
        mk = (mcnt - 1) / 2;
        if (mk < mw) cap[cfg_lsb_first ? mk : mw - 1 - mk] = mp;
      end
    end
    if (!cs_n[cfg_cs_sel]) run++;
    else if (run != 0) begin last_run = run; run = 0; end
    if (rx_overflow) ovf_cnt++;
    sp = sclk; mp = mosi; csp = cs_n;
  end

  task automatic setcfg(input int w, input logic lsb, input logic cpol, input logic cpha,
                        input int dv, input int sel, input logic hold);
    @(negedge clk);
    cfg_width = 6'(w); cfg_lsb_first = lsb; cfg_cpol = cpol; cfg_cpha = cpha;
    cfg_div = 8'(dv); cfg_cs_sel = 2'(sel); cfg_cs_hold = hold;
  endtask

  task automatic push(input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = d;
    while (!tx_ready && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) chk("push_timeout", 32'd0, 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!rx_valid && n < 20000) begin @(negedge clk); n++; end
    chk(tag, rx_data, exp);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (!busy && n < lim) begin @(negedge clk); n++; end
    while (busy && n < lim) begin @(negedge clk); n++; end
    if (n >= lim) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n, ec, o0;
    logic p;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_csn", cs_n, 4'hF);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", rx_overflow, 0);
    chk("rst_txrdy", tx_ready, 1);
    chk("rst_rxv", rx_valid, 0);
    chk("rst_rxd", rx_data, 0);
    rst = 1'b0;

    // mode 0, W=8, MSB, div=1, loopback 0xA5
    setcfg(8, 0, 0, 0, 1, 0, 0);
    loop = 1'b1;
    push(32'hA5);
    chk("t1_busy_t1", busy, 0);
    chk("t1_csn_t1", cs_n, 4'hF);
    @(negedge clk);
    chk("t1_busy_t2", busy, 1);
    chk("t1_csn_t2", cs_n, 4'hE);
    wait_done(1000);
    chk("t1_bits", cap, 32'hA5);
    chk("t1_stable", merr, 0);
    chk("t1_cs_low", last_run, 36);
    pop("t1_rx", 32'hA5);

    // modes 1..3, W=12, LSB-first, slave returns 0x9E1
    for (int m = 1; m < 4; m++) begin
      setcfg(12, 1, m[1], m[0], 2, 1, 0);
      loop = 1'b0; slv = 32'h9E1;
      repeat (2) @(negedge clk);
      chk("t2_idle_pre", sclk, cfg_cpol);
      push(32'h5C3);
      wait_done(2000);
      chk("t2_mosi_word", cap, 32'h5C3);
      chk("t2_stable", merr, 0);
      chk("t2_idle_post", sclk, cfg_cpol);
      pop("t2_rx", 32'h9E1);
    end

    // cs_hold chaining on cs 2, W=16, div=0
    setcfg(16, 0, 0, 0, 0, 2, 1);
    loop = 1'b1;
    push(32'h1234); push(32'hBEEF); push(32'h0F0F);
    wait_done(2000);
    chk("t3_cs_low", last_run, 102);
    pop("t3_rx0", 32'h1234);
    pop("t3_rx1", 32'hBEEF);
    pop("t3_rx2", 32'h0F0F);

    // TX FIFO full with slow first frame; later frames fast after re-latch
    setcfg(8, 0, 0, 0, 255, 0, 0);
    for (int i = 0; i < 9; i++) begin
      push(32'h10 + 32'(i));
      if (i == 7) chk("t4_ready_7", tx_ready, 1);
    end
    chk("t4_full", tx_ready, 0);
    cfg_div = 8'd0;
    n = 0;
    while (!tx_ready && n < 10000) begin @(negedge clk); n++; end
    chk("t4_recover", tx_ready, 1);
    chk("t4_slow_frame", 32'(n > 4000), 1);
    for (int i = 0; i < 9; i++) pop("t4_rx", 32'h10 + 32'(i));

    // RX overflow: 9 frames with no reads
    setcfg(8, 0, 0, 0, 0, 0, 0);
    o0 = ovf_cnt;
    for (int i = 0; i < 9; i++) push(32'h20 + 32'(i));
    repeat (400) @(negedge clk);
    chk("t5_ovf_pulse", ovf_cnt - o0, 1);
    chk("t5_rxv", rx_valid, 1);
    for (int i = 0; i < 8; i++) pop("t5_rx", 32'h20 + 32'(i));
    @(negedge clk);
    chk("t5_rx_empty", rx_valid, 0);

    // reset during XFER after edge 5, with words pending in both FIFOs
    push(32'h55);
    wait_done(500);
    chk("t6_rx_pending", rx_valid, 1);
    setcfg(8, 0, 1, 0, 3, 1, 0);
    repeat (2) @(negedge clk);
    push(32'h77); push(32'h11);
    ec = 0; n = 0; p = sclk;
    while (ec < 5 && n < 1000) begin
      @(negedge clk); n++;
      if (sclk !== p) ec++;
      p = sclk;
    end
    chk("t6_edges", ec, 5);
    #1 rst = 1'b1;
    #1;
    chk("t6_csn", cs_n, 4'hF);
    chk("t6_sclk", sclk, 0);
    chk("t6_busy", busy, 0);
    chk("t6_mosi", mosi, 0);
    chk("t6_txrdy", tx_ready, 1);
    chk("t6_rxv", rx_valid, 0);
    chk("t6_rxd", rx_data, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_sclk_cpol", sclk, 1);
    repeat (5) @(negedge clk);
    chk("t6_tx_flushed", busy, 0);
    chk("t6_rx_flushed", rx_valid, 0);
    setcfg(8, 0, 0, 0, 1, 0, 0);
    push(32'h3C);
    wait_done(1000);
    chk("t6_bits", cap, 32'h3C);
    pop("t6_rx", 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
